seg7_tick_counter: RTL and testbench
====================================

# seg7_tick_counter

Downstream consumer of the divide-by-two toggle stage. Takes that stage's toggling output as `tick_in` and treats every transition as one event. Events pass through a programmable prescaler into a wrapping decimal digit. The digit drives a single 7-segment display on the tile's outputs.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `tick_in` synchronizer, legal range 2..3.
- `DIGIT_MAX`, default 9: last digit value before wrap, legal range 1..15.

Ports:
- `clk`: in, 1 bit. Single clock; all state is on its rising edge.
- `rst_n`: in, 1 bit. Asynchronous, active-low reset.
- `tick_in`: in, 1 bit. Level from the upstream toggle flop; may be asynchronous to `clk`.
- `prescale`: in, 4 bits. Number of events per digit step minus one; 0 means every event steps the digit.
- `hold`: in, 1 bit. Freezes counting while high.
- `digit`: out, 4 bits. Current digit value, binary.
- `seg`: out, 7 bits. Segments, active-high; bit0 = a … bit6 = g.
- `dp`: out, 1 bit. Decimal point.

## Operation
- Synchronizer: `tick_in` passes through `SYNC_STAGES` flops, giving `tick_s`.
- Edge register `tick_q` holds the previous `tick_s`.
- Event: `tick_s != tick_q`. Both rising and falling transitions count.
- Prime: a 1-bit `primed` flag sets `SYNC_STAGES` cycles after reset release. Events are suppressed until `primed` = 1, so a `tick_in` already high at reset causes no spurious count.
- Prescaler `pre_cnt`, 4 bits. On an accepted event:
  - if `pre_cnt >= prescale`, set `pre_cnt` to 0 and step the digit;
  - otherwise increment `pre_cnt`.
- Digit step: if `digit == DIGIT_MAX`, `digit` goes to 0 (wrap); otherwise `digit + 1`.
- Hold: while `hold` = 1, events are discarded and `pre_cnt`/`digit` freeze. `tick_q` keeps tracking `tick_s`, so releasing `hold` creates no stale event.
- `prescale` is compared live. Lowering it below the current `pre_cnt` makes the next event step the digit and clear `pre_cnt`.
- `seg` is a combinational decode of `digit`:
  - 0..9 use the standard patterns (0→0x3F, 1→0x06, … 9→0x6F);
  - 10..15 map to A,b,C,d,E,F (0x77,0x7C,0x39,0x5E,0x79,0x71).
- Reset values: sync chain 0, `tick_q` 0, `primed` 0, `pre_cnt` 0, `digit` 0, `seg` = 0x3F, `dp` = 0.

## Timing
- `tick_in` changes before edge E0; `tick_s` reflects it after edge E0+SYNC_STAGES−1.
- `pre_cnt`/`digit` update at edge E0+SYNC_STAGES. Default latency: 2 edges.
- `seg` follows `digit` in the same cycle (no extra register).
- Maximum accepted event rate: one per clock. The upstream toggle clocked by `clk` produces exactly one event per cycle, and every one is counted.
- `rst_n` low acts immediately, overriding everything including a simultaneous event. Counting resumes only after re-priming.
- `hold` is sampled on the same edge as the event it gates.

## Configuration
- Macro: `SEG7_TICK_DP_STROBE_EN`.
- Defined: `dp` toggles on every digit wrap (`DIGIT_MAX`→0) and resets to 0.
- Undefined: `dp` is tied to 0 and the wrap-toggle flop is not built.

## Structure
- Package `seg7_tick_pkg`:
  - `seg7_t` (7-bit logic);
  - the 16-entry segment pattern constant array;
  - `SEG_BLANK` = 0x00.
- Sub-module `tick_sync_edge`:
  - contains the synchronizer, `tick_q` and `primed`;
  - parameter `SYNC_STAGES`, ports `clk`, `rst_n`, `async_in`, `event_o`.
- Top level holds the prescaler, digit counter, decode and optional dp strobe.

## Test plan
- Reset with `tick_in`=1 held, release, wait 10 cycles: `digit`=0, `seg`=0x3F, no event counted.
- `prescale`=0, toggle `tick_in` every cycle for 12 cycles: `digit` reads 2 (12 mod 10) after the 2-edge latency; `seg`=0x5B.
- `prescale`=3, apply 8 transitions: `digit`=2, `pre_cnt`=0. Apply 1 more: `digit` stays 2, `pre_cnt`=1.
- `hold`=1 during 5 transitions, then release: `digit` unchanged and no extra count on release. `DIGIT_MAX`=9 wrap from 9 to 0 with `SEG7_TICK_DP_STROBE_EN` defined: `dp` 0→1.
- `prescale` 7 with `pre_cnt`=5, change `prescale` to 2, one event: `digit` increments, `pre_cnt`=0.
- Assert `rst_n` low mid-count at `digit`=6: outputs go to reset values without waiting for a clock edge. After release, counting restarts from 0 following re-priming.

Source files
------------

// File: rtl/seg7_tick_pkg.sv
// Shared types and the 7-segment decode table for the tick counter display.
// Segment bits are active-high, bit0 = a .. bit6 = g.
package seg7_tick_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h00;

    // Index 0..9 are decimal digits; 10..15 render as A b C d E F.
    localparam seg7_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg7_t seg_decode(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes an asynchronous toggle level and flags each transition (both
// directions) as a one-cycle event, suppressed until the chain is primed.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic event_o
);

    localparam logic [1:0] PRIME_LOAD = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   tick_s;
    logic                   tick_q;
    logic                   primed;
    logic [1:0]             prime_cnt;

    assign tick_s  = sync_r[SYNC_STAGES-1];
    assign event_o = primed && (tick_s != tick_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r    <= '0;
            tick_q    <= 1'b0;
            primed    <= 1'b0;
            prime_cnt <= PRIME_LOAD;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            // Before priming, tick_q shadows the value tick_s is about to take,
            // so a level already present at reset never looks like a transition.
            if (primed) begin
                tick_q <= tick_s;
            end else begin
                tick_q <= sync_r[SYNC_STAGES-2];
            end
            if (prime_cnt != 2'd0) begin
                prime_cnt <= prime_cnt - 2'd1;
            end
            if (prime_cnt == 2'd1) begin
                primed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_tick_counter.sv
// Counts upstream toggle events through a live-compared prescaler into a
// wrapping digit shown on a 7-segment display. Optional wrap strobe on dp
// is built only when SEG7_TICK_DP_STROBE_EN is defined.
module seg7_tick_counter
    import seg7_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIGIT_MAX   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic [3:0] prescale,
    input  logic       hold,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    logic       tick_event;
    logic       accept;
    logic       step;
    logic       at_max;
    logic [3:0] pre_cnt;

    tick_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (tick_in),
        .event_o  (tick_event)
    );

    assign accept = tick_event && !hold;
    assign step   = accept && (pre_cnt >= prescale);
    assign at_max = (digit == DMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 4'd0;
            digit   <= 4'd0;
        end else if (accept) begin
            if (step) begin
                pre_cnt <= 4'd0;
                digit   <= at_max ? 4'd0 : digit + 4'd1;
            end else begin
                pre_cnt <= pre_cnt + 4'd1;
            end
        end
    end

    assign seg = seg_decode(digit);

`ifdef SEG7_TICK_DP_STROBE_EN
    logic dp_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_r <= 1'b0;
        end else if (step && at_max) begin
            dp_r <= ~dp_r;
        end
    end

    assign dp = dp_r;
`else
    assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_tick_counter.sv
// Directed and randomized checks of seg7_tick_counter against an event-level
// reference model (one model update per tick_in transition).
module tb_seg7_tick_counter;

    localparam int SYNC = 2;
    localparam int DM   = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b1;
    logic [3:0] prescale = 4'd0;
    logic       hold = 1'b0;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       dp;

    int passed = 0;
    int total  = 0;

    int m_pre   = 0;
    int m_digit = 0;
    int m_dp    = 0;

    logic [6:0] exp_seg [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg7_tick_counter #(
        .SYNC_STAGES (SYNC),
        .DIGIT_MAX   (DM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .prescale (prescale),
        .hold     (hold),
        .digit    (digit),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_outputs(input string tag);
        logic exp_dp;
`ifdef SEG7_TICK_DP_STROBE_EN
        exp_dp = m_dp[0];
`else
        exp_dp = 1'b0;
`endif
        check({tag, ".digit"}, {4'd0, digit}, 8'(m_digit));
        check({tag, ".seg"},   {1'b0, seg},   {1'b0, exp_seg[m_digit]});
        check({tag, ".dp"},    {7'd0, dp},    {7'd0, exp_dp});
    endtask

    function automatic void model_event();
        if (hold) return;
        if (m_pre >= int'(prescale)) begin
            m_pre = 0;
            if (m_digit == DM) begin
                m_digit = 0;
                m_dp    = 1 - m_dp;
            end else begin
                m_digit = m_digit + 1;
            end
        end else begin
            m_pre = m_pre + 1;
        end
    endfunction

    // n transitions, gap idle cycles after each, then settle past the latency.
    task automatic apply_events(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
            model_event();
            repeat (gap) @(negedge clk);
        end
        repeat (SYNC + 3) @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset with tick_in high: no spurious count after priming.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_outputs("reset_high_in");
        check("reset_seg", {1'b0, seg}, 8'h3F);

        // Prescale 0, toggle every cycle for 12 cycles.
        apply_events(12, 0);
        check_outputs("every_cycle");
        check("every_cycle_seg", {1'b0, seg}, 8'h5B);

        // Prescale 3: 8 transitions step twice, the 9th only bumps pre_cnt.
        prescale = 4'd3;
        apply_events(8, 1);
        check_outputs("pre3_8");
        apply_events(1, 0);
        check_outputs("pre3_9");
        apply_events(3, 0);
        check_outputs("pre3_12");

        // Hold discards events; releasing hold adds nothing.
        prescale = 4'd0;
        hold = 1'b1;
        apply_events(5, 0);
        check_outputs("hold_on");
        hold = 1'b0;
        repeat (6) @(negedge clk);
        check_outputs("hold_release");

        // Walk to DIGIT_MAX then wrap.
        n = (DM - m_digit + DM + 1) % (DM + 1);
        apply_events(n, 0);
        check_outputs("at_max");
        apply_events(1, 0);
        check_outputs("wrap");

        // Lowering prescale below pre_cnt forces the next event to step.
        prescale = 4'd7;
        apply_events(5, 0);
        check_outputs("pre7_5");
        prescale = 4'd2;
        apply_events(1, 0);
        check_outputs("lower_prescale");
        apply_events(2, 0);
        check_outputs("pre2_after_clear2");
        apply_events(1, 0);
        check_outputs("pre2_after_clear3");

        // Async reset mid-count at digit 6.
        prescale = 4'd0;
        n = (6 - m_digit + DM + 1) % (DM + 1);
        apply_events(n, 0);
        check_outputs("pre_reset_six");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_pre = 0; m_digit = 0; m_dp = 0;
        #1;
        check_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        check_outputs("reprimed");
        apply_events(3, 1);
        check_outputs("restart");

        // Randomized batches.
        for (int it = 0; it < 24; it++) begin
            prescale = 4'($urandom_range(0, 4));
            hold     = ($urandom_range(0, 3) == 0);
            apply_events(int'($urandom_range(1, 12)), int'($urandom_range(0, 2)));
            check_outputs("random");
            hold = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
